// File: rtl/dru_word_gearbox.sv
// dru_word_gearbox: packs 0-3 recovered bits per cycle into WORD_W-bit words, with a one-bit slip.
module dru_word_gearbox #(
  parameter int WORD_W = 8,
  parameter int FILL_W = $clog2(WORD_W + 3)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [2:0]        din,
  input  logic [1:0]        din_nbits,
  input  logic              din_valid,
  input  logic              bitslip,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [FILL_W-1:0] fill,
  output logic              slip_busy
);
  localparam int AW = WORD_W + 2;
  typedef enum logic {IDLE, PEND} slip_t;
  slip_t state, state_nx;
  logic [AW-1:0] acc, cat, acc_nx;
  logic [1:0] n_in, n_eff;
  logic [2:0] d_m, bits;
  logic drop, emit;
  logic [FILL_W-1:0] total, sh;
  // held bits sit LSB-aligned in acc, earliest bit at the highest occupied index
  always_comb begin
    n_in = din_valid ? din_nbits : 2'd0;
    drop = state == PEND && n_in != 2'd0;
    n_eff = n_in - {1'b0, drop};
    d_m = drop ? {1'b0, din[1:0]} : din;
    bits = d_m >> (2'd3 - n_in);
    cat = (acc << n_eff) | AW'(bits);
    total = fill + FILL_W'(n_eff);
    emit = total >= FILL_W'(WORD_W);
    sh = total - FILL_W'(WORD_W);
    acc_nx = emit ? cat & ((AW'(1) << sh) - AW'(1)) : cat;
    state_nx = drop ? IDLE : (bitslip ? PEND : state);
  end
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc <= '0;
      fill <= '0;
      word <= '0;
      word_valid <= 1'b0;
      state <= IDLE;
    end else begin
      acc <= acc_nx;
      fill <= emit ? sh : total;
      word_valid <= emit;
      if (emit) word <= WORD_W'(cat >> sh);
      state <= state_nx;
    end
  end
  assign slip_busy = state == PEND;
endmodule

// File: tb/tb_dru_word_gearbox.sv
// tb_dru_word_gearbox: directed scoreboard bench for the word gearbox (WORD_W=8).
module tb_dru_word_gearbox;
  localparam int W = 8;
  localparam int FW = $clog2(W + 3);
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [2:0] din = '0;
  logic [1:0] din_nbits = '0;
  logic din_valid = 1'b0;
  logic bitslip = 1'b0;
  logic [W-1:0] word;
  logic word_valid;
  logic [FW-1:0] fill;
  logic slip_busy;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_w;

  dru_word_gearbox #(.WORD_W(W)) dut (
    .clk(clk), .aresetn(aresetn), .din(din), .din_nbits(din_nbits),
    .din_valid(din_valid), .bitslip(bitslip), .word(word),
    .word_valid(word_valid), .fill(fill), .slip_busy(slip_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, sample #1 after the edge, score strobe/word/fill/busy
  task automatic step(input logic v, input logic [1:0] nb, input logic [2:0] d,
                      input logic bs, input int exp_fill, input logic exp_busy);
    din_valid = v;
    din_nbits = nb;
    din = d;
    bitslip = bs;
    @(posedge clk);
    #1;
    bitslip = 1'b0;
    din_valid = 1'b0;
    chk("strobe", 32'(word_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      exp_w = sb.pop_front();
      if (word_valid) chk("word", 32'(word), 32'(exp_w));
    end
    chk("fill", 32'(fill), 32'(exp_fill));
    chk("slip_busy", 32'(slip_busy), 32'(exp_busy));
  endtask

  task automatic rst_step(input logic v, input logic [1:0] nb, input logic [2:0] d, input logic bs);
    aresetn = 1'b0;
    din_valid = v;
    din_nbits = nb;
    din = d;
    bitslip = bs;
    @(posedge clk);
    #1;
    bitslip = 1'b0;
    din_valid = 1'b0;
    aresetn = 1'b1;
    chk("rst_word", 32'(word), 0);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_busy", 32'(slip_busy), 0);
  endtask

  initial begin
    // reset held 3 cycles under full-rate input, then one idle cycle after release
    for (int i = 0; i < 3; i++) rst_step(1'b1, 2'd3, 3'b111, 1'b0);
    step(1'b0, 2'd0, 3'b000, 1'b0, 0, 1'b0);
    chk("post_rst_word", 32'(word), 0);
    // steady 2-bit input, unused LSB driven high as don't-care
    step(1'b1, 2'd2, 3'b101, 1'b0, 2, 1'b0);
    step(1'b1, 2'd2, 3'b111, 1'b0, 4, 1'b0);
    step(1'b1, 2'd2, 3'b001, 1'b0, 6, 1'b0);
    sb.push_back(8'b10110001);
    step(1'b1, 2'd2, 3'b011, 1'b0, 0, 1'b0);
    step(1'b0, 2'd0, 3'b000, 1'b0, 0, 1'b0);
    chk("word_hold", 32'(word), 32'(8'b10110001));
    // 3-bit input with a remainder
    step(1'b1, 2'd3, 3'b101, 1'b0, 3, 1'b0);
    step(1'b1, 2'd3, 3'b110, 1'b0, 6, 1'b0);
    sb.push_back(8'b10111001);
    step(1'b1, 2'd3, 3'b011, 1'b0, 1, 1'b0);
    step(1'b1, 2'd3, 3'b000, 1'b0, 4, 1'b0);
    rst_step(1'b0, 2'd0, 3'b000, 1'b0);
    // gaps: invalid and zero-count cycles interleaved
    step(1'b1, 2'd2, 3'b100, 1'b0, 2, 1'b0);
    step(1'b0, 2'd3, 3'b111, 1'b0, 2, 1'b0);
    step(1'b1, 2'd2, 3'b110, 1'b0, 4, 1'b0);
    step(1'b1, 2'd0, 3'b111, 1'b0, 4, 1'b0);
    step(1'b1, 2'd2, 3'b000, 1'b0, 6, 1'b0);
    step(1'b0, 2'd2, 3'b110, 1'b0, 6, 1'b0);
    sb.push_back(8'b10110001);
    step(1'b1, 2'd2, 3'b010, 1'b0, 0, 1'b0);
    rst_step(1'b0, 2'd0, 3'b000, 1'b0);
    // bitslip with no input, then the first pair loses its earliest bit
    step(1'b0, 2'd0, 3'b000, 1'b1, 0, 1'b1);
    step(1'b1, 2'd2, 3'b010, 1'b0, 1, 1'b0);
    step(1'b1, 2'd2, 3'b010, 1'b0, 3, 1'b0);
    step(1'b1, 2'd2, 3'b100, 1'b0, 5, 1'b0);
    step(1'b1, 2'd2, 3'b110, 1'b0, 7, 1'b0);
    sb.push_back(8'b10110110);
    step(1'b1, 2'd2, 3'b000, 1'b0, 1, 1'b0);
    rst_step(1'b0, 2'd0, 3'b000, 1'b0);
    // repeated bitslip while pending drops only one bit
    step(1'b0, 2'd0, 3'b000, 1'b1, 0, 1'b1);
    step(1'b0, 2'd0, 3'b000, 1'b1, 0, 1'b1);
    step(1'b1, 2'd0, 3'b000, 1'b1, 0, 1'b1);
    step(1'b1, 2'd3, 3'b110, 1'b0, 2, 1'b0);
    step(1'b1, 2'd3, 3'b101, 1'b0, 5, 1'b0);
    sb.push_back(8'b10101011);
    step(1'b1, 2'd3, 3'b011, 1'b0, 0, 1'b0);
    // bitslip alongside data: appended unmodified, next bit-bearing cycle drops
    step(1'b1, 2'd3, 3'b111, 1'b1, 3, 1'b1);
    step(1'b1, 2'd2, 3'b010, 1'b0, 4, 1'b0);
    step(1'b1, 2'd1, 3'b111, 1'b1, 5, 1'b1);
    // reset with fill=5 and a slip pending clears both
    rst_step(1'b1, 2'd3, 3'b111, 1'b1);
    step(1'b1, 2'd3, 3'b110, 1'b0, 3, 1'b0);
    step(1'b1, 2'd3, 3'b010, 1'b0, 6, 1'b0);
    sb.push_back(8'b11001010);
    step(1'b1, 2'd2, 3'b101, 1'b0, 0, 1'b0);
    step(1'b0, 2'd0, 3'b000, 1'b0, 0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
